// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs for ALU and LSB, with a
// round-robin grant onto one registered broadcast bus. Flushed by rob_clear_up.
module cdb_arbiter #(
    parameter int ROB_BIT = 4,
    parameter int QDEPTH  = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               rob_clear_up,
    input  logic               alu_valid,
    input  logic [ROB_BIT-1:0] alu_rob_entry,
    input  logic [31:0]        alu_value,
    output logic               alu_stall,
    input  logic               lsb_valid,
    input  logic [ROB_BIT-1:0] lsb_rob_entry,
    input  logic [31:0]        lsb_value,
    output logic               lsb_stall,
    output logic               cdb_valid,
    output logic [ROB_BIT-1:0] cdb_rob_entry,
    output logic [31:0]        cdb_value,
    output logic               cdb_src,
    output logic               err_overflow
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

    // Index 0 is the ALU queue, index 1 the LSB queue.
    logic [ROB_BIT-1:0] r_tag [2][QDEPTH];
    logic [31:0]        r_val [2][QDEPTH];
    logic [PW-1:0]      r_rd  [2];
    logic [PW-1:0]      r_wr  [2];
    logic [CW-1:0]      r_cnt [2];
    src_e               r_last_grant;

    logic [1:0]         w_in_valid;
    logic [ROB_BIT-1:0] w_in_tag [2];
    logic [31:0]        w_in_val [2];
    logic [1:0]         w_stall;
    logic [1:0]         w_ne;
    logic [1:0]         w_push;
    logic [1:0]         w_pop;
    logic               w_active;
    logic               w_overflow;
    logic               w_grant;
    src_e               w_grant_src;
    logic               w_sel;

    assign w_active    = rdy_in && !rob_clear_up;
    assign w_in_valid  = {lsb_valid, alu_valid};
    assign w_in_tag[0] = alu_rob_entry;
    assign w_in_tag[1] = lsb_rob_entry;
    assign w_in_val[0] = alu_value;
    assign w_in_val[1] = lsb_value;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_stall = '0;
        w_ne    = '0;
        w_push  = '0;
        for (int s = 0; s < 2; s++) begin
            w_stall[s] = (r_cnt[s] == CW'(QDEPTH)) || !rdy_in;
            w_ne[s]    = (r_cnt[s] != '0);
            w_push[s]  = w_in_valid[s] && !w_stall[s] && !rob_clear_up;
        end
    end

    assign alu_stall  = w_stall[0];
    assign lsb_stall  = w_stall[1];
    // With rdy_in high, a stall can only mean a full queue.
    assign w_overflow = w_active && |(w_in_valid & w_stall);

    always_comb begin
        w_grant     = 1'b0;
        w_grant_src = SRC_ALU;
        if (w_active) begin
            if (&w_ne) begin
                w_grant     = 1'b1;
                w_grant_src = (r_last_grant == SRC_ALU) ? SRC_LSB : SRC_ALU;
            end else if (w_ne[0]) begin
                w_grant     = 1'b1;
            end else if (w_ne[1]) begin
                w_grant     = 1'b1;
                w_grant_src = SRC_LSB;
            end
        end
    end

    assign w_sel = w_grant_src;
    assign w_pop = {w_grant && (w_grant_src == SRC_LSB),
                    w_grant && (w_grant_src == SRC_ALU)};

    // NOTE: queue storage has no reset; occupancy is tracked by the pointers and counts.
    always_ff @(posedge clk_in) begin
        for (int s = 0; s < 2; s++) begin
            if (w_push[s]) begin
                r_tag[s][r_wr[s]] <= w_in_tag[s];
                r_val[s][r_wr[s]] <= w_in_val[s];
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int s = 0; s < 2; s++) begin
                r_rd[s]  <= '0;
                r_wr[s]  <= '0;
                r_cnt[s] <= '0;
            end
            r_last_grant  <= SRC_LSB;
            cdb_valid     <= 1'b0;
            cdb_rob_entry <= '0;
            cdb_value     <= '0;
            cdb_src       <= 1'b0;
            err_overflow  <= 1'b0;
        end else if (rdy_in) begin
            if (rob_clear_up) begin
                for (int s = 0; s < 2; s++) begin
                    r_rd[s]  <= '0;
                    r_wr[s]  <= '0;
                    r_cnt[s] <= '0;
                end
                r_last_grant <= SRC_LSB;
                cdb_valid    <= 1'b0;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (w_push[s]) r_wr[s] <= r_wr[s] + 1'b1;
                    if (w_pop[s])  r_rd[s] <= r_rd[s] + 1'b1;
                    if (w_push[s] && !w_pop[s])      r_cnt[s] <= r_cnt[s] + 1'b1;
                    else if (!w_push[s] && w_pop[s]) r_cnt[s] <= r_cnt[s] - 1'b1;
                end
                if (w_overflow) err_overflow <= 1'b1;
                if (w_grant) begin
                    cdb_valid     <= 1'b1;
                    cdb_rob_entry <= r_tag[w_sel][r_rd[w_sel]];
                    cdb_value     <= r_val[w_sel][r_rd[w_sel]];
                    cdb_src       <= w_sel;
                    r_last_grant  <= w_grant_src;
                end else begin
                    cdb_valid     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin, overflow,
// flush, freeze and asynchronous reset, each with hand-derived expectations.
module tb_cdb_arbiter;
    localparam int ROB_BIT = 4;
    localparam int QDEPTH  = 2;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               rdy_in;
    logic               rob_clear_up;
    logic               alu_valid;
    logic [ROB_BIT-1:0] alu_rob_entry;
    logic [31:0]        alu_value;
    logic               alu_stall;
    logic               lsb_valid;
    logic [ROB_BIT-1:0] lsb_rob_entry;
    logic [31:0]        lsb_value;
    logic               lsb_stall;
    logic               cdb_valid;
    logic [ROB_BIT-1:0] cdb_rob_entry;
    logic [31:0]        cdb_value;
    logic               cdb_src;
    logic               err_overflow;

    int errors = 0;
    int checks = 0;

    cdb_arbiter #(.ROB_BIT(ROB_BIT), .QDEPTH(QDEPTH)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .rob_clear_up  (rob_clear_up),
        .alu_valid     (alu_valid),
        .alu_rob_entry (alu_rob_entry),
        .alu_value     (alu_value),
        .alu_stall     (alu_stall),
        .lsb_valid     (lsb_valid),
        .lsb_rob_entry (lsb_rob_entry),
        .lsb_value     (lsb_value),
        .lsb_stall     (lsb_stall),
        .cdb_valid     (cdb_valid),
        .cdb_rob_entry (cdb_rob_entry),
        .cdb_value     (cdb_value),
        .cdb_src       (cdb_src),
        .err_overflow  (err_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Values are derived from the tag so a wrong payload shows up as a wrong value.
    function automatic logic [31:0] aval(input logic [3:0] t);
        return 32'hA000_0000 | 32'(t);
    endfunction
    function automatic logic [31:0] lval(input logic [3:0] t);
        return 32'hB000_0000 | 32'(t);
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic drive_alu(input logic v, input logic [3:0] t);
        alu_valid     = v;
        alu_rob_entry = t;
        alu_value     = aval(t);
    endtask

    task automatic drive_lsb(input logic v, input logic [3:0] t);
        lsb_valid     = v;
        lsb_rob_entry = t;
        lsb_value     = lval(t);
    endtask

    task automatic do_reset();
        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        rob_clear_up = 1'b0;
        drive_alu(1'b0, 4'd0);
        drive_lsb(1'b0, 4'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        rob_clear_up = 1'b0;
        drive_alu(1'b0, 4'd0);
        drive_lsb(1'b0, 4'd0);
        #2;
        checks++;
        if ({cdb_valid, cdb_rob_entry, cdb_value, cdb_src} !== '0) begin
            errors++;
            $display("FAIL reset_cdb: got v=%b tag=%0d val=%h src=%b, want all 0",
                     cdb_valid, cdb_rob_entry, cdb_value, cdb_src);
        end
        checks++;
        if (err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b want 0", err_overflow);
        end
        checks++;
        if ({alu_stall, lsb_stall} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stall_rdy1: got %b want 00", {alu_stall, lsb_stall});
        end
        rdy_in = 1'b0;
        #1;
        checks++;
        if ({alu_stall, lsb_stall} !== 2'b11) begin
            errors++;
            $display("FAIL reset_stall_rdy0: got %b want 11", {alu_stall, lsb_stall});
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        cyc();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cdb_valid got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        drive_alu(1'b1, 4'd3);
        cyc();
        drive_alu(1'b0, 4'd0);
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: cdb_valid got %b want 0", cdb_valid);
        end
        cyc();
        checks++;
        if ({cdb_valid, cdb_rob_entry, cdb_value, cdb_src} !== {1'b1, 4'd3, 32'hA000_0003, 1'b0}) begin
            errors++;
            $display("FAIL single_bcast: got v=%b tag=%0d val=%h src=%b, want v=1 tag=3 val=a0000003 src=0",
                     cdb_valid, cdb_rob_entry, cdb_value, cdb_src);
        end
        cyc();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: cdb_valid got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] a_tags [3];
        logic [3:0] l_tags [3];
        int         expect_q [6];
        int         got [$];
        int         ai;
        int         li;
        logic       saw_lsb_stall;
        a_tags   = '{4'd1, 4'd2, 4'd3};
        l_tags   = '{4'd9, 4'd10, 4'd11};
        expect_q = '{1, 9, 2, 10, 3, 11};
        ai = 0;
        li = 0;
        saw_lsb_stall = 1'b0;
        do_reset();
        for (int n = 0; n < 30 && got.size() < 6; n++) begin
            if (cdb_valid === 1'b1) got.push_back(int'(cdb_rob_entry));
            if (lsb_stall === 1'b1) saw_lsb_stall = 1'b1;
            // Producers present only while their stall is low.
            drive_alu((ai < 3) && !alu_stall, (ai < 3) ? a_tags[ai] : 4'd0);
            drive_lsb((li < 3) && !lsb_stall, (li < 3) ? l_tags[li] : 4'd0);
            cyc();
            if (alu_valid) ai++;
            if (lsb_valid) li++;
        end
        drive_alu(1'b0, 4'd0);
        drive_lsb(1'b0, 4'd0);
        checks++;
        if (got.size() != 6) begin
            errors++;
            $display("FAIL rr_count: got %0d results want 6", got.size());
        end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            checks++;
            if (got[i] != expect_q[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got tag %0d want %0d", i, got[i], expect_q[i]);
            end
        end
        checks++;
        if (saw_lsb_stall !== 1'b1) begin
            errors++;
            $display("FAIL rr_lsb_stall: seen %b want 1", saw_lsb_stall);
        end
        checks++;
        if (err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL rr_err: got %b want 0", err_overflow);
        end
        cyc();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_quiet: cdb_valid got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_overflow();
        int got [$];
        int expect_q [5];
        expect_q = '{1, 12, 2, 13, 3};
        do_reset();
        drive_alu(1'b1, 4'd1); drive_lsb(1'b1, 4'd12);
        cyc();
        if (cdb_valid === 1'b1) got.push_back(int'(cdb_rob_entry));
        drive_alu(1'b1, 4'd2); drive_lsb(1'b1, 4'd13);
        cyc();
        if (cdb_valid === 1'b1) got.push_back(int'(cdb_rob_entry));
        drive_alu(1'b1, 4'd3); drive_lsb(1'b0, 4'd0);
        cyc();
        if (cdb_valid === 1'b1) got.push_back(int'(cdb_rob_entry));
        checks++;
        if (alu_stall !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full_stall: alu_stall got %b want 1", alu_stall);
        end
        drive_alu(1'b1, 4'd7);
        cyc();
        if (cdb_valid === 1'b1) got.push_back(int'(cdb_rob_entry));
        drive_alu(1'b0, 4'd0);
        checks++;
        if (err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b want 1", err_overflow);
        end
        for (int n = 0; n < 8; n++) begin
            cyc();
            if (cdb_valid === 1'b1) got.push_back(int'(cdb_rob_entry));
        end
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL ovf_count: got %0d results want 5", got.size());
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++;
            if (got[i] != expect_q[i]) begin
                errors++;
                $display("FAIL ovf_order[%0d]: got tag %0d want %0d", i, got[i], expect_q[i]);
            end
        end
        checks++;
        if (err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b want 1", err_overflow);
        end
    endtask

    task automatic test_flush();
        int stray;
        stray = 0;
        do_reset();
        drive_alu(1'b1, 4'd1); drive_lsb(1'b1, 4'd8);
        cyc();
        drive_alu(1'b1, 4'd2); drive_lsb(1'b0, 4'd0);
        cyc();
        drive_alu(1'b0, 4'd0);
        checks++;
        if ({cdb_valid, cdb_rob_entry, cdb_src} !== {1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL flush_pre: got v=%b tag=%0d src=%b want v=1 tag=1 src=0",
                     cdb_valid, cdb_rob_entry, cdb_src);
        end
        rob_clear_up = 1'b1;
        drive_lsb(1'b1, 4'd5);
        cyc();
        rob_clear_up = 1'b0;
        drive_lsb(1'b0, 4'd0);
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %b want 0", cdb_valid);
        end
        for (int n = 0; n < 4; n++) begin
            cyc();
            if (cdb_valid === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL flush_stray: got %0d broadcasts want 0", stray);
        end
        // A tie right after a flush must go to the ALU.
        drive_alu(1'b1, 4'd6); drive_lsb(1'b1, 4'd14);
        cyc();
        drive_alu(1'b0, 4'd0); drive_lsb(1'b0, 4'd0);
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_lat1: cdb_valid got %b want 0", cdb_valid);
        end
        cyc();
        checks++;
        if ({cdb_valid, cdb_rob_entry, cdb_value, cdb_src} !== {1'b1, 4'd6, 32'hA000_0006, 1'b0}) begin
            errors++;
            $display("FAIL flush_alu_first: got v=%b tag=%0d val=%h src=%b want v=1 tag=6 val=a0000006 src=0",
                     cdb_valid, cdb_rob_entry, cdb_value, cdb_src);
        end
        cyc();
        checks++;
        if ({cdb_valid, cdb_rob_entry, cdb_value, cdb_src} !== {1'b1, 4'd14, 32'hB000_000E, 1'b1}) begin
            errors++;
            $display("FAIL flush_lsb_next: got v=%b tag=%0d val=%h src=%b want v=1 tag=14 val=b000000e src=1",
                     cdb_valid, cdb_rob_entry, cdb_value, cdb_src);
        end
        checks++;
        if (err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_err: got %b want 0", err_overflow);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        drive_alu(1'b1, 4'd4); drive_lsb(1'b1, 4'd9);
        cyc();
        drive_alu(1'b1, 4'd5); drive_lsb(1'b0, 4'd0);
        cyc();
        drive_alu(1'b0, 4'd0);
        rdy_in = 1'b0;
        #1;
        checks++;
        if ({alu_stall, lsb_stall} !== 2'b11) begin
            errors++;
            $display("FAIL freeze_stall: got %b want 11", {alu_stall, lsb_stall});
        end
        for (int n = 0; n < 3; n++) begin
            checks++;
            if ({cdb_valid, cdb_rob_entry, cdb_value, cdb_src} !== {1'b1, 4'd4, 32'hA000_0004, 1'b0}) begin
                errors++;
                $display("FAIL freeze_hold[%0d]: got v=%b tag=%0d val=%h src=%b want v=1 tag=4 val=a0000004 src=0",
                         n, cdb_valid, cdb_rob_entry, cdb_value, cdb_src);
            end
            // A beat offered while frozen is ignored, not an overflow.
            drive_alu(n == 0, 4'd15);
            cyc();
        end
        drive_alu(1'b0, 4'd0);
        checks++;
        if ({cdb_valid, cdb_rob_entry} !== {1'b1, 4'd4}) begin
            errors++;
            $display("FAIL freeze_last: got v=%b tag=%0d want v=1 tag=4", cdb_valid, cdb_rob_entry);
        end
        rdy_in = 1'b1;
        cyc();
        checks++;
        if ({cdb_valid, cdb_rob_entry, cdb_value, cdb_src} !== {1'b1, 4'd9, 32'hB000_0009, 1'b1}) begin
            errors++;
            $display("FAIL freeze_resume_lsb: got v=%b tag=%0d val=%h src=%b want v=1 tag=9 val=b0000009 src=1",
                     cdb_valid, cdb_rob_entry, cdb_value, cdb_src);
        end
        cyc();
        checks++;
        if ({cdb_valid, cdb_rob_entry, cdb_src} !== {1'b1, 4'd5, 1'b0}) begin
            errors++;
            $display("FAIL freeze_resume_alu: got v=%b tag=%0d src=%b want v=1 tag=5 src=0",
                     cdb_valid, cdb_rob_entry, cdb_src);
        end
        cyc();
        checks++;
        if ({cdb_valid, err_overflow} !== 2'b00) begin
            errors++;
            $display("FAIL freeze_drained: got valid=%b err=%b want 0 0", cdb_valid, err_overflow);
        end
    endtask

    task automatic test_async_reset();
        int stray;
        stray = 0;
        do_reset();
        drive_alu(1'b1, 4'd1); drive_lsb(1'b1, 4'd12);
        cyc();
        drive_alu(1'b1, 4'd2); drive_lsb(1'b1, 4'd13);
        cyc();
        drive_alu(1'b1, 4'd3); drive_lsb(1'b0, 4'd0);
        cyc();
        drive_alu(1'b1, 4'd7);
        cyc();
        drive_alu(1'b0, 4'd0);
        checks++;
        if ({cdb_valid, err_overflow} !== 2'b11) begin
            errors++;
            $display("FAIL areset_pre: got valid=%b err=%b want 1 1", cdb_valid, err_overflow);
        end
        #1 rst_in = 1'b0;
        #1;
        checks++;
        if ({cdb_valid, cdb_rob_entry, cdb_value, cdb_src, err_overflow} !== '0) begin
            errors++;
            $display("FAIL areset_now: got v=%b tag=%0d val=%h src=%b err=%b want all 0",
                     cdb_valid, cdb_rob_entry, cdb_value, cdb_src, err_overflow);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int n = 0; n < 6; n++) begin
            cyc();
            if (cdb_valid === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL areset_stale: got %0d broadcasts want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_round_robin();
        test_overflow();
        test_flush();
        test_freeze();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter between the ALU and LSB completion streams. It buffers each producer's results in a small per-source queue and grants one result per cycle onto a single registered CDB. The RS, ROB and LSB snoop that CDB for wakeup and commit. It replaces the direct ALU-only broadcast, so two units finishing in the same cycle never collide, and it empties on `rob_clear_up`.

## Interface
- `ROB_BIT`, 4: width of ROB entry tags.
- `QDEPTH`, 2: per-source queue depth; power of two, ≥2.

- `clk_in`  in  1  system clock; all state on rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global ready; low freezes the block.
- `rob_clear_up`  in  1  misprediction flush.
- `alu_valid`  in  1  ALU result beat.
- `alu_rob_entry`  in  ROB_BIT  ALU result tag.
- `alu_value`  in  32  ALU result value.
- `alu_stall`  out  1  ALU must hold its result; combinational.
- `lsb_valid`  in  1  LSB result beat.
- `lsb_rob_entry`  in  ROB_BIT  LSB result tag.
- `lsb_value`  in  32  LSB result value.
- `lsb_stall`  out  1  LSB must hold its result; combinational.
- `cdb_valid`  out  1  broadcast valid; registered.
- `cdb_rob_entry`  out  ROB_BIT  broadcast tag; registered.
- `cdb_value`  out  32  broadcast value; registered.
- `cdb_src`  out  1  0 = ALU, 1 = LSB; registered.
- `err_overflow`  out  1  sticky; set when a beat arrives while its stall is high.

## Operation
- **Per-source queue.** Each source has a circular FIFO of `QDEPTH` {tag, value} entries. It has a read pointer, a write pointer and a count of width log2(QDEPTH)+1. Pointers wrap modulo QDEPTH.
- **Stall.** `x_stall = (count_x == QDEPTH) || !rdy_in`.
- **Enqueue.** `x_valid && !x_stall` writes at the tail at the edge.
- **Overflow.** `x_valid && x_stall` while `rdy_in` is high drops the beat and sets `err_overflow`. Beats presented while `rdy_in` is low are ignored and do not set the flag.
- **Arbitration.** Combinational on the queue heads.
  - One non-empty queue: grant it.
  - Both non-empty: grant the source not granted last time (`last_grant` register).
  - `last_grant` updates only on a grant.
- **Grant.** Pops the head, loads `cdb_*` from it and sets `cdb_valid = 1`.
- **No grant.** `cdb_valid <= 0`. `cdb_rob_entry`, `cdb_value` and `cdb_src` hold their previous values.
- **Same-cycle push and pop.** On one queue, the count is unchanged and both pointers advance. This is legal at any fill level below full; a full queue cannot be pushed because its stall is high.
- **Flush.** `rob_clear_up` with `rdy_in` high:
  - both queues are emptied (pointers and counts set to 0);
  - same-cycle input beats are discarded;
  - no grant is made, so `cdb_valid <= 0`;
  - `last_grant` is set to LSB, so the ALU wins the next tie;
  - `err_overflow` is unchanged.
- **Freeze.** `rdy_in` low: no state changes, and all registered outputs hold, including `cdb_valid`.
- **Reset values** (`rst_in` low, immediate and asynchronous):
  - queues empty;
  - `last_grant` = LSB;
  - `cdb_valid`, `cdb_rob_entry`, `cdb_value`, `cdb_src` and `err_overflow` all 0;
  - `alu_stall` and `lsb_stall` equal `!rdy_in`.

## Timing
- **Latency.** A beat accepted at edge E into an empty queue, with no competing head, appears on `cdb_*` in the cycle after edge E+1, i.e. 2 cycles.
- **Pulse width.** `cdb_valid` is high for exactly one cycle per result.
- **Throughput.** One result per cycle total. With both sources continuously active, grants alternate A, L, A, L…
- **Stall handshake.**
  - Stall is computed from registered count, so a producer sees full in the cycle after the filling edge.
  - A producer holds `x_valid`, tag and value stable while its stall is high.
- **Reset.** Deassertion of `rst_in` may occur at any time. The first enqueue can happen at the first rising edge after deassertion.
- **Reset mid-operation.** Queued results are lost and `cdb_valid` drops without waiting for an edge.

## Test plan
- **Single beat.** `alu_valid=1`, tag 3, value 0x11 for one cycle at cycle 1 → `cdb_valid=1`, tag 3, value 0x11, `cdb_src=0` during cycle 3 only; `cdb_valid` is 0 in cycle 4.
- **Tie and round-robin.** ALU (tags 1,2,3) and LSB (tags 9,10,11) both issue every cycle from cycle 1. Check:
  - CDB order is 1,9,2,10,3,11 (ALU first after reset);
  - no beat is lost;
  - `lsb_stall` rises once the LSB queue holds 2 and the producer honours it;
  - `err_overflow` stays 0.
- **Overflow.** Fill the ALU queue with `QDEPTH=2`, then force `alu_valid=1` tag 7 while `alu_stall=1` → tag 7 is never broadcast and `err_overflow=1` persists until reset.
- **Flush.** Load 2 ALU and 1 LSB results, then assert `rob_clear_up` for one cycle together with a new LSB beat (tag 5). Check:
  - `cdb_valid=0` the next cycle;
  - none of the flushed tags, nor tag 5, ever appear;
  - a later ALU beat emerges 2 cycles after acceptance.
- **Freeze.** Drop `rdy_in` for 3 cycles while `cdb_valid=1` with tag 4 → `cdb_*` hold tag 4 with valid high, both stalls are 1, and queue contents are unchanged; draining resumes the cycle after `rdy_in` rises.
- **Asynchronous reset.** Pull `rst_in` low mid-cycle with both queues non-empty → all `cdb_*` and `err_overflow` go to 0 before the next edge; after release, no stale results appear.
